// File: rtl/regfile_access_ctrl.sv
// Client-side access controller for a 1W/2R register-file RAM: buffers writebacks in a
// 2-entry FIFO, schedules one RAM operation per cycle and forwards buffered data to reads.
module regfile_access_ctrl #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_src_a,
    input  logic [AW-1:0] rd_src_b,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_op_a,
    output logic [DW-1:0] rd_op_b,
    input  logic          wb_req,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_ready,
    output logic [AW-1:0] rf_addr_a,
    output logic [AW-1:0] rf_addr_b,
    output logic [AW-1:0] rf_addr_d,
    output logic [DW-1:0] rf_data_in,
    output logic          rf_we,
    input  logic [DW-1:0] rf_q_a,
    input  logic [DW-1:0] rf_q_b
);

    // Entry 0 is always the head (oldest); draining shifts entry 1 down.
    logic [AW-1:0] fifo_addr_reg [2];
    logic [DW-1:0] fifo_data_reg [2];
    logic [1:0]    count_reg;
    logic          rd_valid_reg;

    logic          drain;
    logic          issue;
    logic          accept;
    logic          wr_sel;
    logic [AW-1:0] src [2];
    logic [DW-1:0] rf_q [2];
    logic [DW-1:0] rd_op [2];

    always_comb begin
        wb_ready   = (count_reg != 2'd2);
        accept     = wb_req && wb_ready;
        rd_ready   = rd_req && (count_reg != 2'd2);
        issue      = rd_ready;
        drain      = (count_reg == 2'd2) || ((count_reg != 2'd0) && !rd_req);
        rf_we      = drain;
        rf_addr_a  = rd_src_a;
        rf_addr_b  = rd_src_b;
        rf_addr_d  = (count_reg != 2'd0) ? fifo_addr_reg[0] : '0;
        rf_data_in = (count_reg != 2'd0) ? fifo_data_reg[0] : '0;
        // Slot for a new entry once this cycle's pop (if any) has been applied.
        wr_sel     = count_reg[0] & ~drain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_addr_reg[i] <= '0;
                fifo_data_reg[i] <= '0;
            end
            count_reg    <= 2'd0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (drain) begin
                fifo_addr_reg[0] <= fifo_addr_reg[1];
                fifo_data_reg[0] <= fifo_data_reg[1];
            end
            if (accept) begin
                fifo_addr_reg[wr_sel] <= wb_addr;
                fifo_data_reg[wr_sel] <= wb_data;
            end
            count_reg    <= count_reg + 2'(accept) - 2'(drain);
            rd_valid_reg <= issue;
        end
    end

    assign src[0]   = rd_src_a;
    assign src[1]   = rd_src_b;
    assign rf_q[0]  = rf_q_a;
    assign rf_q[1]  = rf_q_b;
    assign rd_valid = rd_valid_reg;
    assign rd_op_a  = rd_op[0];
    assign rd_op_b  = rd_op[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic          hit;
            logic [DW-1:0] data;
            logic          hit_reg;
            logic [DW-1:0] data_reg;

            // Candidates checked oldest to youngest so the youngest match wins.
            always_comb begin
                hit  = 1'b0;
                data = '0;
                if ((count_reg != 2'd0) && (fifo_addr_reg[0] == src[gi])) begin
                    hit  = 1'b1;
                    data = fifo_data_reg[0];
                end
                if ((count_reg == 2'd2) && (fifo_addr_reg[1] == src[gi])) begin
                    hit  = 1'b1;
                    data = fifo_data_reg[1];
                end
                if (accept && (wb_addr == src[gi])) begin
                    hit  = 1'b1;
                    data = wb_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hit_reg  <= 1'b0;
                    data_reg <= '0;
                end else if (issue) begin
                    hit_reg  <= hit;
                    data_reg <= data;
                end
            end

            assign rd_op[gi] = !rd_valid_reg ? '0 : (hit_reg ? data_reg : rf_q[gi]);
        end
    endgenerate

endmodule
